// File: rtl/side_info_sequencer.sv
// side_info_sequencer
//
// Frame-level sequencer in front of the side_info_2ch parser. It takes the
// post-header byte stream of one MP3 frame and strips the optional 16-bit CRC.
// It then meters 17 (mono) or 32 (stereo) side-info bytes to the parser and
// forwards the remaining payload as main data. A parse watchdog reports parser
// completion (si_done) or timeout (err).
//
// Build option: define SIDE_INFO_CRC_CAPTURE_EN to capture the CRC bytes into
// crc_word. Without it crc_word is constant 0. Sequencing is the same in both
// builds.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   hdr_valid         header pulse; hdr_mono / hdr_protect / frame_bytes valid
//   axiid, axiiv      input payload byte stream (no backpressure)
//   si_axiid/iv       bytes to the side-info parser
//   si_axiov          parser output-valid pulse
//   md_axiid/iv       main-data bytes, md_last on the final payload byte
//   si_done           parser finished for this frame
//   busy              sequencer is inside a frame
//   err               pulse: short frame, header while busy, or parse timeout
//   crc_word          captured CRC (first byte in [15:8])
//
// State table
//   state | meaning
//   IDLE  | waiting for hdr_valid, input bytes dropped
//   CRC   | swallowing the two CRC bytes
//   SIDE  | forwarding side-info bytes to the parser
//   MAIN  | forwarding main-data bytes until the frame count runs out

module side_info_sequencer #(
    parameter int PARSE_TIMEOUT = 64,
    parameter int LEN_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hdr_valid,
    input  logic             hdr_mono,
    input  logic             hdr_protect,
    input  logic [LEN_W-1:0] frame_bytes,
    input  logic [7:0]       axiid,
    input  logic             axiiv,
    output logic [7:0]       si_axiid,
    output logic             si_axiiv,
    input  logic             si_axiov,
    output logic [7:0]       md_axiid,
    output logic             md_axiiv,
    output logic             md_last,
    output logic             si_done,
    output logic             busy,
    output logic             err,
    output logic [15:0]      crc_word
);

    typedef enum logic [1:0] {IDLE, CRC, SIDE, MAIN} state_t;

    localparam int WD_W = $clog2(PARSE_TIMEOUT + 1);

    state_t           state;
    state_t           eff_state;
    logic [LEN_W-1:0] rem_cnt;
    logic [LEN_W-1:0] rem_eff;
    logic [LEN_W-1:0] need;
    logic [5:0]       side_left;
    logic [5:0]       side_left_eff;
    logic             crc_first;
    logic             crc_first_eff;
    logic             hdr_ok;
    logic             byte_ok;
    logic             arm_wd;
    logic             wd_armed;
    logic [WD_W-1:0]  wd_cnt;

`ifdef SIDE_INFO_CRC_CAPTURE_EN
    logic [7:0]       crc_hi;
`else
    assign crc_word = '0;
`endif

    // A byte arriving together with an accepted header belongs to the new
    // frame, so byte handling works on the "effective" state and counters:
    // the freshly loaded values when a header is accepted this cycle.
    always_comb begin
        need          = LEN_W'(hdr_protect ? 0 : 2) + LEN_W'(hdr_mono ? 17 : 32);
        hdr_ok        = hdr_valid && (state == IDLE) && (frame_bytes >= need);
        eff_state     = state;
        rem_eff       = rem_cnt;
        side_left_eff = side_left;
        crc_first_eff = crc_first;
        if (hdr_ok) begin
            eff_state     = hdr_protect ? SIDE : CRC;
            rem_eff       = frame_bytes;
            side_left_eff = hdr_mono ? 6'd17 : 6'd32;
            crc_first_eff = 1'b1;
        end
        byte_ok = axiiv && (eff_state != IDLE);
        arm_wd  = byte_ok && (eff_state == SIDE) && (side_left_eff == 6'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rem_cnt   <= '0;
            side_left <= '0;
            crc_first <= 1'b0;
            wd_armed  <= 1'b0;
            wd_cnt    <= '0;
            si_axiid  <= '0;
            si_axiiv  <= 1'b0;
            md_axiid  <= '0;
            md_axiiv  <= 1'b0;
            md_last   <= 1'b0;
            si_done   <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
`ifdef SIDE_INFO_CRC_CAPTURE_EN
            crc_hi    <= '0;
            crc_word  <= '0;
`endif
        end else begin
            si_axiiv <= 1'b0;
            md_axiiv <= 1'b0;
            md_last  <= 1'b0;
            si_done  <= 1'b0;
            err      <= 1'b0;

            // Covers both a short frame and a header arriving mid-frame.
            if (hdr_valid && !hdr_ok)
                err <= 1'b1;

            if (hdr_ok) begin
                state     <= eff_state;
                busy      <= 1'b1;
                rem_cnt   <= rem_eff;
                side_left <= side_left_eff;
                crc_first <= 1'b1;
            end

            if (byte_ok) begin
                rem_cnt <= rem_eff - 1'b1;
                case (eff_state)
                    CRC: begin
                        crc_first <= 1'b0;
                        if (!crc_first_eff)
                            state <= SIDE;
`ifdef SIDE_INFO_CRC_CAPTURE_EN
                        if (crc_first_eff)
                            crc_hi <= axiid;
                        else
                            crc_word <= {crc_hi, axiid};
`endif
                    end
                    SIDE: begin
                        si_axiid  <= axiid;
                        si_axiiv  <= 1'b1;
                        side_left <= side_left_eff - 6'd1;
                        if (side_left_eff == 6'd1) begin
                            if (rem_eff == LEN_W'(1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= MAIN;
                            end
                        end
                    end
                    MAIN: begin
                        md_axiid <= axiid;
                        md_axiiv <= 1'b1;
                        if (rem_eff == LEN_W'(1)) begin
                            md_last <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            // Watchdog: down-counter loaded at arm time, expiry at terminal
            // count. A parser pulse in the expiry cycle takes priority.
            if (hdr_ok) begin
                wd_armed <= 1'b0;
            end else if (arm_wd) begin
                wd_armed <= 1'b1;
                wd_cnt   <= WD_W'(PARSE_TIMEOUT - 1);
            end else if (wd_armed) begin
                if (si_axiov) begin
                    si_done  <= 1'b1;
                    wd_armed <= 1'b0;
                end else if (wd_cnt == '0) begin
                    err      <= 1'b1;
                    wd_armed <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt - 1'b1;
                end
            end
        end
    end

endmodule
